truth_table_bist: RTL

- Hardware stimulus/response engine for small combinational boolean blocks.
- Drives every input combination into a DUT function, waits a settle time, then samples the DUT output.
- Builds the captured truth table and compares it against an expected truth table.
- Sits on the driving side of a boolean block; replaces a bench-only exhaustive sweep with synthesizable self-test.

---
 rtl/truth_table_bist_pkg.sv | 25 ++
 rtl/truth_table_bist.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/truth_table_bist_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_bist_pkg
// Shared definitions for the truth-table BIST engine:
//   - bist_state_t : sweep controller states
//   - DEFAULT_N_IN / DEFAULT_SETTLE : default input count and settle time
//   - num_vec()    : number of input combinations for a given input count
// -----------------------------------------------------------------------------
package truth_table_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_t;

  localparam int unsigned DEFAULT_N_IN   = 3;
  localparam int unsigned DEFAULT_SETTLE = 1;

  // Exhaustive sweep length: every combination of n boolean inputs.
  function automatic int unsigned num_vec(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage : truth_table_bist_pkg

// File: rtl/truth_table_bist.sv
// -----------------------------------------------------------------------------
// truth_table_bist
// Exhaustive stimulus/response engine for a small combinational boolean block.
// On start it walks every input vector, holds each one for SETTLE cycles,
// samples the block's response, and builds the captured truth table while
// comparing it against an expected table latched at start.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   start          in   sweep request, honoured only in IDLE
//   expected_tt    in   expected response, bit i = F(vector i)
//   dut_in         out  vector driven to the block (MSB = input A)
//   dut_out        in   block response, synchronous to clk
//   busy           out  sweep in progress
//   done           out  one-cycle completion pulse
//   pass           out  captured table matched expected (valid from done)
//   fail_count     out  number of mismatching vectors (never wraps)
//   first_fail_idx out  lowest mismatching vector index, 0 if none
//   captured_tt    out  sampled responses, bit i = dut_out at vector i
// -----------------------------------------------------------------------------
module truth_table_bist
  import truth_table_bist_pkg::*;
#(
  parameter  int unsigned N_IN    = DEFAULT_N_IN,
  parameter  int unsigned SETTLE  = DEFAULT_SETTLE,   // legal 1..15
  localparam int unsigned NUM_VEC = num_vec(N_IN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_VEC-1:0] expected_tt,
  output logic [N_IN-1:0]    dut_in,
  input  logic               dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_IN:0]      fail_count,
  output logic [N_IN-1:0]    first_fail_idx,
  output logic [NUM_VEC-1:0] captured_tt
);

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(NUM_VEC - 1);
  localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   FC_ONE      = (N_IN + 1)'(1);
  localparam logic [3:0]      CNT_ONE     = 4'd1;

  bist_state_t        state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [NUM_VEC-1:0] exp_q, exp_d;
  logic [NUM_VEC-1:0] cap_q, cap_d;
  logic [N_IN:0]      fc_q, fc_d;
  logic [N_IN-1:0]    ff_q, ff_d;
  logic               pass_q, pass_d;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      fc_q    <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      fc_q    <= fc_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no
    // path through the case statement can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    cap_d   = cap_q;
    fc_d    = fc_q;
    ff_d    = ff_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected_tt;
          cap_d   = '0;
          fc_d    = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end

      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      SAMPLE: begin
        cap_d[idx_q] = dut_out;
        if (dut_out != exp_q[idx_q]) begin
          fc_d = fc_q + FC_ONE;
          // A zero running count means this is the first mismatch seen.
          if (fc_q == '0) ff_d = idx_q;
        end
        if (idx_q == IDX_LAST) begin
          // idx stays on the last vector rather than wrapping to 0.
          pass_d  = (fc_d == '0);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = DRIVE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Status and stimulus decode straight from registers, so an asynchronous
  // reset clears them immediately without waiting for an edge.
  assign dut_in         = (state_q == DRIVE || state_q == SAMPLE) ? idx_q : '0;
  assign busy           = (state_q == DRIVE || state_q == SAMPLE);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign fail_count     = fc_q;
  assign first_fail_idx = ff_q;
  assign captured_tt    = cap_q;

endmodule : truth_table_bist
